// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_decoder: PS/2 Set-2 receiver and playback command key decoder.    |
// | Optional macro KEY_RELEASE_CLEAR_EN: releasing the held key clears key.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {PF_NORMAL, PF_BREAK, PF_EXT, PF_EXT_BREAK} pf_state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_data;

    rx_state_t              r_rx_state;
    pf_state_t              r_pf_state;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_parity;
    logic [TW-1:0]          r_tmo_cnt;
    logic [8:0]             w_map;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_data = r_data_sync[SYNC_STAGES-1];

    // Bit 8 flags a mapped make code; bits 7:0 carry its ASCII command.
    function automatic logic [8:0] map_make(input logic [7:0] code);
        case (code)
            8'h24:   map_make = {1'b1, 8'h45};
            8'h23:   map_make = {1'b1, 8'h44};
            8'h2B:   map_make = {1'b1, 8'h46};
            8'h32:   map_make = {1'b1, 8'h42};
            8'h2D:   map_make = {1'b1, 8'h52};
            default: map_make = 9'h000;
        endcase
    endfunction

    assign w_map = map_make(r_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_pf_state <= PF_NORMAL;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_tmo_cnt  <= '0;
            key        <= 8'h00;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (w_fall) begin
                r_tmo_cnt <= '0;
                case (r_rx_state)
                    RX_IDLE: begin
                        if (!w_data) begin
                            r_rx_state <= RX_DATA;
                            r_bit_cnt  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        r_parity   <= w_data;
                        r_rx_state <= RX_STOP;
                    end
                    default: begin
                        r_rx_state <= RX_IDLE;
                        if (w_data && (^{r_shift, r_parity})) begin
                            case (r_pf_state)
                                PF_NORMAL: begin
                                    if (r_shift == 8'hF0)
                                        r_pf_state <= PF_BREAK;
                                    else if (r_shift == 8'hE0)
                                        r_pf_state <= PF_EXT;
                                    else if (w_map[8]) begin
                                        key       <= w_map[7:0];
                                        key_valid <= 1'b1;
                                    end
                                end
                                PF_BREAK: begin
                                    r_pf_state <= PF_NORMAL;
`ifdef KEY_RELEASE_CLEAR_EN
                                    // Only the release of the currently held command clears it.
                                    if (w_map[8] && (w_map[7:0] == key)) begin
                                        key       <= 8'h00;
                                        key_valid <= 1'b1;
                                    end
`endif
                                end
                                PF_EXT: begin
                                    r_pf_state <= (r_shift == 8'hF0) ? PF_EXT_BREAK : PF_NORMAL;
                                end
                                default: r_pf_state <= PF_NORMAL;
                            endcase
                        end else begin
                            frame_err  <= 1'b1;
                            r_pf_state <= PF_NORMAL;
                        end
                    end
                endcase
            end else if (r_rx_state != RX_IDLE) begin
                // Timeout abandons the frame but leaves the prefix context alone.
                if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err  <= 1'b1;
                    r_rx_state <= RX_IDLE;
                    r_tmo_cnt  <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_key_decoder: randomized PS/2 stimulus with queued expected events. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ps2_key_decoder;

    localparam int S    = 2;
    localparam int TMO  = 100;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       key_valid;
    logic       frame_err;

    ps2_key_decoder #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] k;
        bit         lat;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] mkey = 8'h00;
    bit         in_break = 0;
    bit         in_ext = 0;
    logic [7:0] makes [5] = '{8'h24, 8'h23, 8'h2B, 8'h32, 8'h2D};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit lookup(input logic [7:0] b, output logic [7:0] a);
        case (b)
            8'h24: a = "E";
            8'h23: a = "D";
            8'h2B: a = "F";
            8'h32: a = "B";
            8'h2D: a = "R";
            default: a = 8'h00;
        endcase
        return a != 8'h00;
    endfunction

    function automatic void push(input bit err, input logic [7:0] k, input bit lat);
        exp_t e;
        e.err = err; e.k = k; e.lat = lat; e.cyc = cyc;
        q.push_back(e);
    endfunction

    // Interpret one good byte in terms of the keyboard protocol's prefix rules.
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] a;
        bit hit;
        hit = lookup(b, a);
        if (in_break) begin
`ifdef KEY_RELEASE_CLEAR_EN
            if (!in_ext && hit && a == mkey) begin
                mkey = 8'h00;
                push(0, mkey, 1);
            end
`endif
            in_break = 0;
            in_ext = 0;
        end else if (in_ext) begin
            if (b == 8'hF0) in_break = 1;
            else in_ext = 0;
        end else if (b == 8'hF0) begin
            in_break = 1;
        end else if (b == 8'hE0) begin
            in_ext = 1;
        end else if (hit) begin
            mkey = a;
            push(0, mkey, 1);
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (key_valid || frame_err)) begin
            exp_t e;
            compared++;
            if (key_valid && frame_err) begin
                mismatched++;
                $display("FAIL pulse_overlap: key_valid and frame_err both high at cycle %0d", cyc);
            end else if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: kv=%b err=%b key=%h at cycle %0d", key_valid, frame_err, key, cyc);
            end else begin
                e = q.pop_front();
                if (e.err != frame_err || (!e.err && key !== e.k) ||
                    (e.lat && (cyc - e.cyc) != S + 1)) begin
                    mismatched++;
                    $display("FAIL event: got err=%b key=%h delay=%0d expected err=%b key=%h delay=%0d",
                             frame_err, key, cyc - e.cyc, e.err, e.k, e.lat ? S + 1 : -1);
                end
            end
        end
    end

    task automatic ps2_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge clk) ps2_data = bits[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (bad_par || bad_stop) begin
            push(1, 8'h00, 1);
            in_break = 0;
            in_ext = 0;
        end else begin
            model_byte(b);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i]);
        push(1, 8'h00, 0);
        repeat (TMO + 20) @(negedge clk);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        #1;
        check("reset_key", key, 8'h00);
        check("reset_kv", {7'd0, key_valid}, 8'h00);
        check("reset_err", {7'd0, frame_err}, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(8'h24, 0, 0);
        check("key_after_24", key, 8'h45);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h24, 0, 0);
        send_frame(8'h32, 0, 0);
        check("key_after_32", key, 8'h42);
        send_frame(8'h23, 1, 0);
        check("key_after_bad_parity", key, 8'h42);
        send_frame(8'h23, 0, 0);
        check("key_after_23", key, 8'h44);
        send_partial(8'h55);
        send_frame(8'h2B, 0, 0);
        check("key_after_timeout", key, 8'h46);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h24, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h24, 0, 0);
        check("key_after_ext", key, 8'h46);
        send_frame(8'h24, 0, 0);
        check("key_after_ext_24", key, 8'h45);
        send_frame(8'h24, 0, 1);

        // Reset in the middle of a frame's data bits.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_key", key, 8'h00);
        check("midrst_kv", {7'd0, key_valid}, 8'h00);
        check("midrst_err", {7'd0, frame_err}, 8'h00);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        mkey = 8'h00;
        in_break = 0;
        in_ext = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h2D, 0, 0);
        check("key_after_reset", key, 8'h52);

        repeat (60) begin
            b = makes[$urandom_range(0, 4)];
            case ($urandom_range(0, 7))
                0, 1: send_frame(b, 0, 0);
                2: send_frame(8'($urandom), 0, 0);
                3: begin send_frame(8'hF0, 0, 0); send_frame(($urandom_range(0, 1) != 0) ? mkey_code(mkey) : b, 0, 0); end
                4: begin send_frame(8'hE0, 0, 0); send_frame(b, 0, 0); end
                5: begin send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(b, 0, 0); end
                6: send_frame(8'($urandom), $urandom_range(0, 1) == 0, 1'b1);
                default: send_partial(8'($urandom));
            endcase
        end

        repeat (20) @(negedge clk);
        check("queue_drained", 8'(q.size()), 8'h00);
        check("final_key", key, mkey);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Make code of the currently held key, so random breaks hit it often.
    function automatic logic [7:0] mkey_code(input logic [7:0] a);
        case (a)
            "E": return 8'h24;
            "D": return 8'h23;
            "F": return 8'h2B;
            "B": return 8'h32;
            "R": return 8'h2D;
            default: return 8'h1C;
        endcase
    endfunction

endmodule
`default_nettype wire
